multicycle_controller: RTL

- Moore-style control FSM that sequences a multicycle RV32 datapath. The datapath is built from the existing regfile, ALU, extender, mux and data_memory blocks, sharing one memory port and one ALU.
- Decodes opcode/funct from the instruction register and drives every mux select, write enable and ALU operation, one micro-step per clock.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-ALU (addi/andi/ori/slti), beq, jal, lui.
- Adds a memory-ready handshake and an illegal-instruction halt.

---
 rtl/multicycle_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32 datapath: decodes the instruction register
// and sequences one micro-step per clock, with a memory-ready handshake.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_dec_next;
  state_t     w_illegal_next;
  logic       w_f3_ok;
  logic [2:0] w_alu_op;

  // Only these funct3 codes map onto the ALU; anything else is caught in DECODE.
  always_comb begin
    w_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
              (funct3 == 3'b110) || (funct3 == 3'b111);
    w_illegal_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
  end

  always_comb begin
    w_dec_next = w_illegal_next;
    case (opcode)
      OP_LW, OP_SW: w_dec_next = S_MEMADR;
      OP_R:         w_dec_next = w_f3_ok ? S_EXECR : w_illegal_next;
      OP_I:         w_dec_next = w_f3_ok ? S_EXECI : w_illegal_next;
      OP_BEQ:       w_dec_next = S_BEQ;
      OP_JAL:       w_dec_next = S_JAL;
      OP_LUI:       w_dec_next = S_LUI;
      default:      w_dec_next = w_illegal_next;
    endcase
  end

  // SUB is only selected by R-type; I-type funct7b5 is part of the immediate.
  always_comb begin
    w_alu_op = ALU_ADD;
    case (funct3)
      3'b000:  w_alu_op = (r_state == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_op = ALU_SLT;
      3'b110:  w_alu_op = ALU_OR;
      3'b111:  w_alu_op = ALU_AND;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_dec_next;
        S_MEMADR:   r_state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR,
        S_EXECI,
        S_JAL:      r_state <= S_ALUWB;
        S_MEMWB,
        S_ALUWB,
        S_BEQ,
        S_LUI:      r_state <= S_FETCH;
        S_HALT:     r_state <= S_HALT;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from the current state; handshake terms pass straight through
  // so a stalled access holds its enables in the same cycle.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    reg_write   = 1'b0;
    alu_control = ALU_ADD;
    imm_src     = 3'b000;
    instr_done  = 1'b0;
    halted      = 1'b0;
    state       = 4'd0;
    if (!rst) begin
      state = r_state;
      case (r_state)
        S_FETCH: begin
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_JAL) ? 3'b011 : 3'b010;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_SW) ? 3'b001 : 3'b000;
        end
        S_MEMREAD: adr_src = 1'b1;
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src    = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          alu_src_a   = 2'b10;
          alu_control = w_alu_op;
        end
        S_EXECI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = w_alu_op;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BEQ: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          pc_write    = zero;
          instr_done  = 1'b1;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          imm_src    = 3'b100;
          result_src = 2'b11;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
